// File: rtl/ctrl_50mhz_pkg.sv
// Shared defaults and packet-state type for the ctrl_50mhz serial-to-FIFO packet controller.
package ctrl_50mhz_pkg;

  localparam logic [7:0] HDR_A_DEF         = 8'hA5;
  localparam logic [7:0] HDR_B_DEF         = 8'hC3;
  localparam int         BYTES_PER_PKT_DEF = 4;

  typedef enum logic {
    HDR_WAIT = 1'b0,
    DATA     = 1'b1
  } pkt_state_e;

endpackage

// File: rtl/ctrl_50mhz_ser2byte.sv
// Serial-to-byte deserializer: MSB-first shift register with a bit counter that
// restarts whenever data_ena drops, so partial bytes never complete.
module ser2byte (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       serial_data,
  input  logic       data_ena,
  output logic [7:0] byte_o,
  output logic       byte_done_o
);

  logic [7:0] shreg_q, shreg_d;
  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = 3'd0;
    if (data_ena) begin
      shreg_d = {shreg_q[6:0], serial_data};
      cnt_d   = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q <= 8'h00;
      cnt_q   <= 3'd0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // The completed byte includes the bit being sampled on this edge.
  assign byte_o      = shreg_d;
  assign byte_done_o = data_ena && (cnt_q == 3'd7);

endmodule

// File: rtl/ctrl_50mhz.sv
// Packet controller: waits for a header byte, then forwards BYTES_PER_PKT data bytes to a FIFO.
// Optional sticky overflow flag on dropped bytes is built when CTRL_50MHZ_OVF_EN is defined.
module ctrl_50mhz
  import ctrl_50mhz_pkg::*;
#(
  parameter logic [7:0] HDR_A         = HDR_A_DEF,
  parameter logic [7:0] HDR_B         = HDR_B_DEF,
  parameter int         BYTES_PER_PKT = BYTES_PER_PKT_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       serial_data,
  input  logic       data_ena,
  input  logic       fifo_full,
  output logic [7:0] fifo_data,
  output logic       wr_fifo
`ifdef CTRL_50MHZ_OVF_EN
  ,
  output logic       ovf
`endif
);

  localparam logic [2:0] LAST_IDX = 3'(BYTES_PER_PKT - 1);

  logic [7:0] byte_w;
  logic       byte_done_w;

  pkt_state_e state_q;
  logic [2:0] byte_cnt_q;
  logic [7:0] fifo_data_q;
  logic       wr_fifo_q;
`ifdef CTRL_50MHZ_OVF_EN
  logic       ovf_q;
`endif

  ser2byte u_ser2byte (
    .clk         (clk),
    .reset_n     (reset_n),
    .serial_data (serial_data),
    .data_ena    (data_ena),
    .byte_o      (byte_w),
    .byte_done_o (byte_done_w)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HDR_WAIT;
      byte_cnt_q  <= 3'd0;
      fifo_data_q <= 8'h00;
      wr_fifo_q   <= 1'b0;
`ifdef CTRL_50MHZ_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      wr_fifo_q <= 1'b0;
      if (byte_done_w) begin
        case (state_q)
          HDR_WAIT: begin
            if ((byte_w == HDR_A) || (byte_w == HDR_B)) begin
              state_q    <= DATA;
              byte_cnt_q <= 3'd0;
            end
          end
          DATA: begin
            // Dropped bytes still advance the count to keep packet alignment.
            if (byte_cnt_q == LAST_IDX) begin
              state_q    <= HDR_WAIT;
              byte_cnt_q <= 3'd0;
            end else begin
              byte_cnt_q <= byte_cnt_q + 3'd1;
            end
            if (!fifo_full) begin
              wr_fifo_q   <= 1'b1;
              fifo_data_q <= byte_w;
            end
`ifdef CTRL_50MHZ_OVF_EN
            else begin
              ovf_q <= 1'b1;
            end
`endif
          end
          default: state_q <= HDR_WAIT;
        endcase
      end
    end
  end

  assign fifo_data = fifo_data_q;
  assign wr_fifo   = wr_fifo_q;
`ifdef CTRL_50MHZ_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_ctrl_50mhz.sv
// Bench for ctrl_50mhz: directed packet scenarios plus randomized traffic against a packet-level model.
module tb_ctrl_50mhz;

  localparam logic [7:0] HA  = 8'hA5;
  localparam logic [7:0] HB  = 8'hC3;
  localparam int         BPP = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       serial_data;
  logic       data_ena;
  logic       fifo_full;
  logic [7:0] fifo_data;
  logic       wr_fifo;
`ifdef CTRL_50MHZ_OVF_EN
  logic       ovf;
`endif

  int total = 0;
  int bad   = 0;

  // Packet-level reference state
  bit         m_in_pkt;
  int         m_left;
  logic [7:0] m_last;
  bit         m_ovf;

  always #10 clk = ~clk;

  ctrl_50mhz dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .serial_data (serial_data),
    .data_ena    (data_ena),
    .fifo_full   (fifo_full),
    .fifo_data   (fifo_data),
    .wr_fifo     (wr_fifo)
`ifdef CTRL_50MHZ_OVF_EN
    ,
    .ovf         (ovf)
`endif
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_in_pkt = 0;
    m_left   = 0;
    m_last   = 8'h00;
    m_ovf    = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit full, output bit exp_wr);
    exp_wr = 0;
    if (!m_in_pkt) begin
      if (b == HA || b == HB) begin
        m_in_pkt = 1;
        m_left   = BPP;
      end
    end else begin
      m_left--;
      if (m_left == 0) m_in_pkt = 0;
      if (full) m_ovf = 1;
      else begin
        exp_wr = 1;
        m_last = b;
      end
    end
  endtask

  task automatic check_outputs(input string tag, input bit exp_wr);
    chk({tag, ".wr"}, {7'd0, wr_fifo}, {7'd0, exp_wr});
    chk({tag, ".data"}, fifo_data, m_last);
`ifdef CTRL_50MHZ_OVF_EN
    chk({tag, ".ovf"}, {7'd0, ovf}, {7'd0, m_ovf});
`endif
  endtask

  // Called at a negedge; returns at the negedge after the 8th bit is sampled.
  task automatic send_byte(input logic [7:0] b, input bit full);
    bit exp_wr;
    for (int i = 7; i >= 0; i--) begin
      serial_data = b[i];
      data_ena    = 1'b1;
      fifo_full   = (i == 0) ? full : 1'b0;
      @(negedge clk);
      if (i != 0) chk("mid_byte.wr", {7'd0, wr_fifo}, 8'd0);
    end
    model_byte(b, full, exp_wr);
    check_outputs("byte", exp_wr);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      serial_data = b[7-i];
      data_ena    = 1'b1;
      fifo_full   = 1'b0;
      @(negedge clk);
      chk("partial.wr", {7'd0, wr_fifo}, 8'd0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      serial_data = 1'b0;
      data_ena    = 1'b0;
      fifo_full   = 1'b0;
      @(negedge clk);
      chk("idle.wr", {7'd0, wr_fifo}, 8'd0);
    end
  endtask

  task automatic do_reset(input int n);
    reset_n     = 1'b0;
    data_ena    = 1'b0;
    serial_data = 1'b0;
    fifo_full   = 1'b0;
    model_reset();
    #1;
    check_outputs("reset", 1'b0);
    repeat (n) @(negedge clk);
    check_outputs("reset_hold", 1'b0);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [7:0] rb;
    reset_n     = 1'b0;
    serial_data = 1'b0;
    data_ena    = 1'b0;
    fifo_full   = 1'b0;
    @(negedge clk);
    do_reset(3);
    idle(2);

    // Basic packet with header A
    send_byte(8'hA5, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
    send_byte(8'h33, 0); send_byte(8'h44, 0);
    idle(3);

    // Non-header bytes ignored before header B
    send_byte(8'h5A, 0); send_byte(8'h00, 0); send_byte(8'hC3, 0);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
    idle(2);

    // Header values inside a packet are data; trailing 33 must be ignored
    send_byte(8'hA5, 0); send_byte(8'hA5, 0); send_byte(8'hC3, 0);
    send_byte(8'h10, 0); send_byte(8'h20, 0); send_byte(8'h33, 0);
    idle(2);

    // FIFO full on second data byte, then a normal packet
    send_byte(8'hA5, 0); send_byte(8'h61, 0); send_byte(8'h62, 1);
    send_byte(8'h63, 0); send_byte(8'h64, 0);
    send_byte(8'hA5, 0); send_byte(8'h71, 0); send_byte(8'h72, 0);
    send_byte(8'h73, 0); send_byte(8'h74, 0);
    idle(2);

    // Partial byte discarded
    send_byte(8'hA5, 0);
    send_partial(8'hFF, 5);
    idle(1);
    send_byte(8'h77, 0);
    send_byte(8'h78, 0); send_byte(8'h79, 0); send_byte(8'h7A, 0);
    idle(2);

    // Reset mid-packet and mid-byte
    send_byte(8'hC3, 0); send_byte(8'h81, 0); send_byte(8'h82, 0);
    send_partial(8'hF0, 3);
    do_reset(2);
    send_byte(8'h10, 0); send_byte(8'h20, 0); send_byte(8'h30, 0);
    send_byte(8'h40, 0); send_byte(8'h50, 0);
    idle(2);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    rb = ($urandom_range(0, 1) == 0) ? HA : HB;
        default: rb = 8'($urandom);
      endcase
      send_byte(rb, ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 19) == 0) begin
        send_partial(8'($urandom), $urandom_range(1, 7));
        idle(1);
      end
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
